ped_btn_conditioner: RTL

Conditions the raw pedestrian push-button before it reaches the traffic-light controller. It synchronises and debounces the button and latches a single request. It holds `ped_btn` high until the controller serves it by granting pedestrian green. After service it enforces a hold-off gap so a held or re-pressed button cannot immediately re-trigger a cycle. It sits directly upstream of the controller and drives its `ped_btn` input.

---
 rtl/ped_btn_conditioner.sv | 114 +++++++++++
 1 files changed

// File: rtl/ped_btn_conditioner.sv
// rtl/ped_btn_conditioner.sv - pedestrian button synchroniser, debouncer and request latch with hold-off
// Optional saturating press counter on press_count when PED_PRESS_CNT_EN is defined.
module ped_btn_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int HOLDOFF_CYCLES  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  input  logic       ped_walk,
  output logic       ped_btn,
  output logic       wait_lamp
`ifdef PED_PRESS_CNT_EN
  ,
  output logic [7:0] press_count
`endif
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HO_LAST = HW'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ARMED, SERVING, HOLDOFF} state_t;

  logic [SYNC_STAGES-1:0] sync;
  logic                   btn_s;
  logic                   db;
  logic                   db_prev;
  logic [DW-1:0]          db_cnt;
  logic                   press;
  logic [HW-1:0]          ho_cnt;
  logic                   pending;
  logic                   pending_next;
  state_t                 state;
  state_t                 state_next;

  assign btn_s = sync[SYNC_STAGES-1];
  assign press = db & ~db_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync    <= '0;
      db      <= 1'b0;
      db_prev <= 1'b0;
      db_cnt  <= '0;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], btn_raw};
      db_prev <= db;
      if (btn_s == db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db     <= btn_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_next   = state;
    pending_next = pending;
    case (state)
      IDLE:    if (press) state_next = ARMED;
      ARMED:   if (ped_walk) state_next = SERVING;
      SERVING: if (!ped_walk) state_next = HOLDOFF;
      HOLDOFF: begin
        if (press) pending_next = 1'b1;
        if (ho_cnt == HO_LAST) begin
          pending_next = 1'b0;
          state_next   = (pending || press) ? ARMED : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change on the same edge as the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pending   <= 1'b0;
      ho_cnt    <= '0;
      ped_btn   <= 1'b0;
      wait_lamp <= 1'b0;
    end else begin
      state     <= state_next;
      pending   <= pending_next;
      ped_btn   <= (state_next == ARMED);
      wait_lamp <= (state_next == ARMED) || ((state_next == HOLDOFF) && pending_next);
      if (state == SERVING) begin
        ho_cnt <= '0;
      end else if ((state == HOLDOFF) && (ho_cnt != HO_LAST)) begin
        ho_cnt <= ho_cnt + 1'b1;
      end
    end
  end

`ifdef PED_PRESS_CNT_EN
  logic arm_event;
  assign arm_event = (state_next == ARMED) && ((state == IDLE) || (state == HOLDOFF));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press_count <= 8'd0;
    end else if (arm_event && (press_count != 8'hFF)) begin
      press_count <= press_count + 8'd1;
    end
  end
`endif

endmodule
